hazard_ctrl: RTL and testbench

//  Pipeline hazard/sequencing controller for the 5-stage core; companion to the forwarding unit.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_perf_cnt.sv | 37 +++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use hazard: a load in EX writes a register that the ID instruction really reads.
    // Writes to x0 never create a dependency.
    function automatic logic is_loaduse(
        input logic       mem_read,
        input logic [4:0] wa,
        input logic [4:0] ra1,
        input logic [4:0] ra2,
        input logic       use_ra1,
        input logic       use_ra2
    );
        return mem_read && (wa != REG_ZERO) &&
               ((use_ra1 && (ra1 == wa)) || (use_ra2 && (ra2 == wa)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, pipeline register controls out.
// The perf counter outputs (and CNT_W) exist only with HAZARD_PERF_CNT_EN.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic       MemRead_IDEX;
    logic [4:0] WA_IDEX;
    logic [4:0] RF_RA1;
    logic [4:0] RF_RA2;
    logic       UseRA1;
    logic       UseRA2;
    logic       RedirectEX;
    logic       isHalt_ID;
    logic       MemStall;
    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       PipeFreeze;
    logic       HALTED;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] CntLoadUse;
    logic [CNT_W-1:0] CntFlush;
    logic [CNT_W-1:0] CntMemStall;

    modport master (
        output MemRead_IDEX, WA_IDEX, RF_RA1, RF_RA2, UseRA1, UseRA2,
               RedirectEX, isHalt_ID, MemStall,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze, HALTED,
               CntLoadUse, CntFlush, CntMemStall
    );
    modport slave (
        input  MemRead_IDEX, WA_IDEX, RF_RA1, RF_RA2, UseRA1, UseRA2,
               RedirectEX, isHalt_ID, MemStall,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze, HALTED,
               CntLoadUse, CntFlush, CntMemStall
    );
`else
    modport master (
        output MemRead_IDEX, WA_IDEX, RF_RA1, RF_RA2, UseRA1, UseRA2,
               RedirectEX, isHalt_ID, MemStall,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze, HALTED
    );
    modport slave (
        input  MemRead_IDEX, WA_IDEX, RF_RA1, RF_RA2, UseRA1, UseRA2,
               RedirectEX, isHalt_ID, MemStall,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze, HALTED
    );
`endif
endinterface

// File: rtl/hazard_perf_cnt.sv
// One saturating event counter; sticks at all-ones instead of wrapping.
module hazard_perf_cnt
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Next value: increment on an event unless already saturated.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {CNT_W{1'b1}})) begin
            value_d = value_q + CNT_W'(1);
        end else begin
            value_d = value_q;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value_q <= {CNT_W{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use bubble, redirect flush,
// memory-stall freeze and HALT drain. Outputs are combinational from state and inputs.
// Define HAZARD_PERF_CNT_EN to add the load-use / flush / mem-stall counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYC = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic CLK,
    input  logic RST,
    hazard_ctrl_if.slave bus
);

    // Drain counter counts completed drain cycles; DRAIN_CYC is expected to be >= 2.
    localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic [DW-1:0] cnt_inc_s;
    logic          loaduse_s;
    logic          bubble_s;
    logic          flush_s;

    assign loaduse_s = is_loaduse(bus.MemRead_IDEX, bus.WA_IDEX, bus.RF_RA1, bus.RF_RA2,
                                  bus.UseRA1, bus.UseRA2);
    assign cnt_inc_s = cnt_q + DW'(1);

    // Next state and pipeline controls, by priority MemStall > RedirectEX > loaduse > HALT.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus.PCWrite    = 1'b1;
        bus.IFID_Write = 1'b1;
        bus.IFID_Flush = 1'b0;
        bus.IDEX_Flush = 1'b0;
        bus.PipeFreeze = 1'b0;
        bus.HALTED     = 1'b0;
        bubble_s       = 1'b0;
        flush_s        = 1'b0;
        case (state_q)
            S_HALT: begin
                bus.HALTED     = 1'b1;
                bus.PCWrite    = 1'b0;
                bus.IFID_Write = 1'b0;
                bus.PipeFreeze = 1'b1;
            end
            S_RUN, S_DRAIN: begin
                if (bus.MemStall) begin
                    // Whole pipe frozen; FSM and counter hold, pending events re-evaluated later.
                    bus.PCWrite    = 1'b0;
                    bus.IFID_Write = 1'b0;
                    bus.PipeFreeze = 1'b1;
                end else if (bus.RedirectEX) begin
                    // Wrong-path IF and ID discarded; a HALT being drained was also wrong-path.
                    bus.IFID_Flush = 1'b1;
                    bus.IDEX_Flush = 1'b1;
                    flush_s        = 1'b1;
                    state_d        = S_RUN;
                    cnt_d          = {DW{1'b0}};
                end else if (state_q == S_DRAIN) begin
                    // Stop fetching and let the instructions ahead of the HALT retire.
                    bus.PCWrite    = 1'b0;
                    bus.IFID_Write = 1'b0;
                    bus.IFID_Flush = 1'b1;
                    cnt_d          = cnt_inc_s;
                    if (cnt_inc_s == DRAIN_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (loaduse_s) begin
                    // Hold PC and IF/ID for one cycle, bubble into EX.
                    bus.PCWrite    = 1'b0;
                    bus.IFID_Write = 1'b0;
                    bus.IDEX_Flush = 1'b1;
                    bubble_s       = 1'b1;
                end else if (bus.isHalt_ID) begin
                    state_d = S_DRAIN;
                    cnt_d   = {DW{1'b0}};
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = {DW{1'b0}};
            end
        endcase
    end

    // State and drain counter registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_RUN;
            cnt_q   <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_loaduse (
        .CLK(CLK), .RST(RST), .inc(bubble_s), .value(bus.CntLoadUse)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .CLK(CLK), .RST(RST), .inc(flush_s), .value(bus.CntFlush)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_memstall (
        .CLK(CLK), .RST(RST), .inc(bus.MemStall), .value(bus.CntMemStall)
    );
`else
    logic unused_s;
    assign unused_s = bubble_s ^ flush_s;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Output vector order:
// {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze, HALTED}.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    logic [5:0] o;
    assign o = {bus.PCWrite, bus.IFID_Write, bus.IFID_Flush,
                bus.IDEX_Flush, bus.PipeFreeze, bus.HALTED};

    localparam logic [5:0] O_NORM  = 6'b110000;
    localparam logic [5:0] O_LU    = 6'b000100;
    localparam logic [5:0] O_RDIR  = 6'b111100;
    localparam logic [5:0] O_STALL = 6'b000010;
    localparam logic [5:0] O_DRAIN = 6'b001000;
    localparam logic [5:0] O_HALT  = 6'b000011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] wa, input logic [4:0] ra1,
                          input logic [4:0] ra2, input logic u1, input logic u2,
                          input logic rd, input logic hlt, input logic ms);
        bus.MemRead_IDEX = mr;
        bus.WA_IDEX      = wa;
        bus.RF_RA1       = ra1;
        bus.RF_RA2       = ra2;
        bus.UseRA1       = u1;
        bus.UseRA2       = u2;
        bus.RedirectEX   = rd;
        bus.isHalt_ID    = hlt;
        bus.MemStall     = ms;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", o, O_NORM);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (bus.CntFlush !== 32'd0 || bus.CntLoadUse !== 32'd0 || bus.CntMemStall !== 32'd0) begin
            n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                              bus.CntLoadUse, bus.CntFlush, bus.CntMemStall);
        end
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic test_loaduse();
        do_reset();
        // lw x5 in EX, add x6,x5,x1 in ID
        set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_LU) begin
            n_err++; $display("FAIL loaduse_bubble: got %b expected %b", o, O_LU);
        end
        tick();
        // Bubble now in EX, load in MEM
        set_in(1'b0, 5'd0, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL loaduse_after: got %b expected %b", o, O_NORM);
        end
        tick();
        // Match through RA2 with UseRA2 set
        set_in(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_LU) begin
            n_err++; $display("FAIL loaduse_ra2: got %b expected %b", o, O_LU);
        end
        tick();
        idle();
    endtask

    task automatic test_no_stall();
        do_reset();
        // lw x0 in EX, ID reads x0 on both ports
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL nostall_x0: got %b expected %b", o, O_NORM);
        end
        tick();
        // lw x5 in EX, addi whose RA2 field is x5 but unused
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL nostall_ra2_unused: got %b expected %b", o, O_NORM);
        end
        tick();
        idle();
    endtask

    task automatic test_redirect_vs_loaduse();
        do_reset();
        set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_RDIR) begin
            n_err++; $display("FAIL redirect_over_loaduse: got %b expected %b", o, O_RDIR);
        end
        tick();
        idle();
        #2;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL redirect_after: got %b expected %b", o, O_NORM);
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            #2;
            n_cmp++;
            if (o !== O_STALL) begin
                n_err++; $display("FAIL stall_redirect_c%0d: got %b expected %b", i, o, O_STALL);
            end
            tick();
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_RDIR) begin
            n_err++; $display("FAIL stall_redirect_fire: got %b expected %b", o, O_RDIR);
        end
        tick();
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (bus.CntMemStall !== 32'd3 || bus.CntFlush !== 32'd1) begin
            n_err++; $display("FAIL stall_counters: got ms=%0d fl=%0d expected ms=3 fl=1",
                              bus.CntMemStall, bus.CntFlush);
        end
`endif
        idle();
    endtask

    task automatic test_halt_drain();
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL halt_decode: got %b expected %b", o, O_NORM);
        end
        tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            #2;
            n_cmp++;
            if (o !== O_DRAIN) begin
                n_err++; $display("FAIL halt_drain_c%0d: got %b expected %b", i, o, O_DRAIN);
            end
            tick();
        end
        #2;
        n_cmp++;
        if (o !== O_HALT) begin
            n_err++; $display("FAIL halt_reached_c4: got %b expected %b", o, O_HALT);
        end
        tick();
        // Redirect is ignored once halted
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_HALT) begin
            n_err++; $display("FAIL halt_held: got %b expected %b", o, O_HALT);
        end
        idle();
        // Asynchronous reset out of halt, well away from a clock edge
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o !== O_NORM) begin
            n_err++; $display("FAIL halt_async_reset: got %b expected %b", o, O_NORM);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_halt_stall();
        logic [5:0] exp_v [5];
        exp_v[0] = O_DRAIN;
        exp_v[1] = O_STALL;
        exp_v[2] = O_DRAIN;
        exp_v[3] = O_DRAIN;
        exp_v[4] = O_HALT;
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 1) bus.MemStall = 1'b1;
            #2;
            n_cmp++;
            if (o !== exp_v[i]) begin
                n_err++; $display("FAIL halt_stall_c%0d: got %b expected %b", i + 1, o, exp_v[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_halt_redirect();
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (o !== O_RDIR) begin
            n_err++; $display("FAIL halt_redirect_flush: got %b expected %b", o, O_RDIR);
        end
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            #2;
            n_cmp++;
            if (o !== O_NORM) begin
                n_err++; $display("FAIL halt_redirect_run_c%0d: got %b expected %b", i, o, O_NORM);
            end
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (bus.CntFlush !== 32'd1) begin
            n_err++; $display("FAIL halt_redirect_cntflush: got %0d expected 1", bus.CntFlush);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_loaduse();
        test_no_stall();
        test_redirect_vs_loaduse();
        test_stall_redirect();
        test_halt_drain();
        test_halt_stall();
        test_halt_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
